// File: rtl/sa_fmap_reader.sv
// Drain stage for the accumulate/pool block: waits for all enabled pool lanes,
// then reads the pooled map from the SA-data BRAM and streams it out over valid/ready.
module sa_fmap_reader #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LANES  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [LANES-1:0]  lane_mask_i,
    input  logic [4:0]        pool_size_i,
    input  logic [5:0]        ch_i,
    input  logic [LANES-1:0]  pool_last_i,
    output logic              sa_rden_o,
    output logic [ADDR_W-1:0] sa_rdptr_o,
    input  logic [DATA_W-1:0] sa_rdata_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    input  logic              m_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_WORDS = 32'(1) << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic [LANES-1:0]   sticky_q, sticky_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               inflight_q;
    logic               infl_last_q;
    logic [DATA_W-1:0]  fdata_q [2];
    logic [1:0]         flast_q;
    logic               wr_q;
    logic               rd_q;
    logic [1:0]         count_q, count_d;

    logic [CNT_W-1:0]   n_c;
    logic               oversize_c;
    logic               issue_c;
    logic               last_c;
    logic               push_c;
    logic               pop_c;

    // Word count of the requested map; the 16-bit product is exact for 5b*5b*6b.
    assign n_c        = CNT_W'(pool_size_i) * CNT_W'(pool_size_i) * CNT_W'(ch_i);
    assign oversize_c = 32'(n_c) > MAX_WORDS;

    // One read in flight plus FIFO occupancy never exceeds the two skid entries.
    assign issue_c = (state_q == S_READ) && (n_q != '0)
                     && ((3'(count_q) + 3'(inflight_q)) < 3'd2);
    assign last_c  = (CNT_W'(addr_q) == (n_q - CNT_W'(1)));
    assign push_c  = inflight_q;
    assign pop_c   = (count_q != 2'd0) && m_ready_i;

    always_comb begin
        count_d = count_q;
        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Next-state and control decode.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        sticky_d = sticky_q;
        n_d      = n_q;
        addr_d   = addr_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sticky_d = '0;
                if (start_i) begin
                    if (oversize_c) begin
                        err_d = 1'b1;
                    end else begin
                        mask_d  = lane_mask_i;
                        n_d     = n_c;
                        addr_d  = '0;
                        state_d = S_ARM;
                    end
                end
            end
            S_ARM: begin
                sticky_d = sticky_q | pool_last_i;
                if (((sticky_q | pool_last_i) & mask_q) == mask_q) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (n_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (issue_c) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (last_c) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as the final pop empties the FIFO so busy_o falls with done_o.
                if ((count_d == 2'd0) && !issue_c) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            sticky_q <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            sticky_q <= sticky_d;
            n_q      <= n_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Read-latency tracking and the 2-entry skid FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            fdata_q[0]  <= '0;
            fdata_q[1]  <= '0;
            flast_q     <= '0;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            count_q     <= '0;
        end else begin
            inflight_q  <= issue_c;
            infl_last_q <= issue_c && last_c;
            if (push_c) begin
                fdata_q[wr_q] <= sa_rdata_i;
                flast_q[wr_q] <= infl_last_q;
                wr_q          <= ~wr_q;
            end
            if (pop_c) begin
                rd_q <= ~rd_q;
            end
            count_q <= count_d;
        end
    end

    assign sa_rden_o  = issue_c;
    assign sa_rdptr_o = addr_q;
    assign m_valid_o  = (count_q != 2'd0);
    assign m_data_o   = fdata_q[rd_q];
    assign m_last_o   = flast_q[rd_q];
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_sa_fmap_reader.sv
// Scoreboard bench for sa_fmap_reader: stimulus pushes expected words, a negedge
// monitor checks reads, stream handshakes, hold behaviour and done timing.
module tb_sa_fmap_reader;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned LANES  = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [LANES-1:0]  lane_mask_i;
    logic [4:0]        pool_size_i;
    logic [5:0]        ch_i;
    logic [LANES-1:0]  pool_last_i;
    logic              sa_rden_o;
    logic [ADDR_W-1:0] sa_rdptr_o;
    logic [DATA_W-1:0] sa_rdata_i;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_last_o;
    logic              m_ready_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    int         pop_cnt = 0;
    int         done_cnt = 0;
    int         exp_rd_addr = 0;
    int         ready_mode = 0;
    logic [7:0] bram_off = 8'h00;

    always #5 clk = ~clk;

    sa_fmap_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .lane_mask_i(lane_mask_i),
        .pool_size_i(pool_size_i), .ch_i(ch_i), .pool_last_i(pool_last_i),
        .sa_rden_o(sa_rden_o), .sa_rdptr_o(sa_rdptr_o), .sa_rdata_i(sa_rdata_i),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .m_ready_i(m_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    // BRAM model: one-cycle read latency, content = address + offset.
    always @(posedge clk) begin
        if (sa_rden_o) sa_rdata_i <= 8'(sa_rdptr_o) + bram_off;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_rden"},  32'(sa_rden_o),  0);
        chk({p, "_rdptr"}, 32'(sa_rdptr_o), 0);
        chk({p, "_valid"}, 32'(m_valid_o),  0);
        chk({p, "_data"},  32'(m_data_o),   0);
        chk({p, "_last"},  32'(m_last_o),   0);
        chk({p, "_busy"},  32'(busy_o),     0);
        chk({p, "_done"},  32'(done_o),     0);
        chk({p, "_err"},   32'(err_o),      0);
    endtask

    task automatic push_word(input logic [7:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic push_seq(input int n, input logic [7:0] off);
        for (int i = 0; i < n; i++) push_word(8'(i) + off, i == n - 1);
    endtask

    task automatic start_run(input logic [4:0] sz, input logic [5:0] c, input logic [15:0] mask);
        @(posedge clk); #1;
        rd_cnt      = 0;
        pop_cnt     = 0;
        exp_rd_addr = 0;
        start_i     = 1'b1;
        pool_size_i = sz;
        ch_i        = c;
        lane_mask_i = mask;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] v);
        pool_last_i = v;
        @(posedge clk); #1;
        pool_last_i = '0;
    endtask

    task automatic wait_done(input string name, input int n_exp);
        int c0;
        bit ok;
        c0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk);
            if (done_cnt != c0) ok = 1'b1;
        end
        chk({name, "_done_seen"},   32'(ok), 1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 0);
        chk({name, "_read_count"},  32'(rd_cnt), 32'(n_exp));
        exp_q.delete();
    endtask

    // Consumer back-pressure: always ready, or the repeating 1,0,0,1 pattern.
    initial begin
        int k;
        k = 0;
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1) m_ready_i = ((k % 4) == 0) || ((k % 4) == 3);
            else                 m_ready_i = 1'b1;
            k++;
        end
    end

    // Monitor: read addresses, occupancy bound, stream words, stall hold, done timing.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        logic       last_pop;
        exp_t       e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        last_pop   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                last_pop   = 1'b0;
            end else begin
                if (last_pop) begin
                    chk("done_after_last", 32'(done_o), 1);
                    chk("busy_low_with_done", 32'(busy_o), 0);
                end
                if (done_o) done_cnt++;
                if (prev_stall) begin
                    chk("hold_valid", 32'(m_valid_o), 1);
                    chk("hold_data",  32'(m_data_o),  32'(prev_data));
                    chk("hold_last",  32'(m_last_o),  32'(prev_last));
                end
                if (sa_rden_o) begin
                    chk("rd_addr", 32'(sa_rdptr_o), 32'(exp_rd_addr));
                    chk("outstanding_lt2", 32'((rd_cnt - pop_cnt) < 2), 1);
                    rd_cnt++;
                    exp_rd_addr++;
                end
                last_pop = 1'b0;
                if (m_valid_o && m_ready_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_word: got 0x%0h expected none at %0t", m_data_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", 32'(m_data_o), 32'(e.data));
                        chk("word_last", 32'(m_last_o), 32'(e.last));
                        last_pop = e.last;
                    end
                    pop_cnt++;
                end
                prev_stall = m_valid_o && !m_ready_i;
                prev_data  = m_data_o;
                prev_last  = m_last_o;
            end
        end
    end

    initial begin
        int d0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        lane_mask_i = '0;
        pool_size_i = '0;
        ch_i        = '0;
        pool_last_i = '0;
        #22;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic drain: 4 words, BRAM returns addr+0x10.
        bram_off = 8'h10;
        push_word(8'h10, 1'b0);
        push_word(8'h11, 1'b0);
        push_word(8'h12, 1'b0);
        push_word(8'h13, 1'b1);
        start_run(5'd2, 6'd1, 16'h000F);
        pulse(16'h000F);
        @(negedge clk);
        chk("basic_first_rden", 32'(sa_rden_o), 1);
        chk("basic_busy", 32'(busy_o), 1);
        @(negedge clk);
        chk("basic_valid_early", 32'(m_valid_o), 0);
        @(negedge clk);
        chk("basic_valid_lat2", 32'(m_valid_o), 1);
        wait_done("basic", 4);

        // Staggered lanes: 0..5, 5 again, 6..15, one per cycle.
        bram_off = 8'h20;
        push_seq(4, 8'h20);
        start_run(5'd2, 6'd1, 16'hFFFF);
        for (int i = 0; i < 17; i++) begin
            int lane;
            lane = (i <= 5) ? i : i - 1;
            pool_last_i = 16'(1) << lane;
            @(negedge clk);
            chk("stagger_no_early_read", 32'(sa_rden_o), 0);
            @(posedge clk); #1;
        end
        pool_last_i = '0;
        @(negedge clk);
        chk("stagger_read_start", 32'(sa_rden_o), 1);
        wait_done("stagger", 4);

        // Back-pressure: N=18 with ready 1,0,0,1.
        ready_mode = 1;
        bram_off   = 8'h30;
        push_seq(18, 8'h30);
        start_run(5'd3, 6'd2, 16'h0003);
        pulse(16'h0003);
        wait_done("bp", 18);
        ready_mode = 0;

        // Oversize: 31*31*63 = 60543 > 16384.
        d0 = done_cnt;
        start_run(5'd31, 6'd63, 16'h0001);
        @(negedge clk);
        chk("over_err_pulse", 32'(err_o), 1);
        chk("over_busy", 32'(busy_o), 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("over_err_clear", 32'(err_o), 0);
        chk("over_busy_after", 32'(busy_o), 0);
        pulse(16'h0001);
        repeat (5) @(posedge clk);
        chk("over_no_reads", 32'(rd_cnt), 0);
        chk("over_no_done", 32'(done_cnt), 32'(d0));

        // Zero size: done pulse, no reads, no words.
        start_run(5'd0, 6'd4, 16'h0001);
        pulse(16'h0001);
        wait_done("zero", 0);
        chk("zero_no_words", 32'(pop_cnt), 0);

        // Reset after 5 words of an N=16 run, then a clean run.
        bram_off = 8'h50;
        push_seq(16, 8'h50);
        start_run(5'd4, 6'd1, 16'h0003);
        pulse(16'h0003);
        for (int i = 0; i < 200 && pop_cnt < 5; i++) @(posedge clk);
        chk("rstmid_words_before", 32'(pop_cnt), 5);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("rstmid");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bram_off = 8'h60;
        push_seq(4, 8'h60);
        start_run(5'd2, 6'd1, 16'h000F);
        pulse(16'h000F);
        wait_done("after_rst", 4);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
